// File: rtl/lsu.sv
// Load/store unit: turns one execute-stage memory op into a word-aligned SRAM
// access, lane-aligns store data, extends load data and stalls until completion.
module lsu #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [4:0]  req_rd_i,
   output logic        hold_o,
   output logic        done_o,
   output logic        rsp_wen_o,
   output logic [4:0]  rsp_rd_o,
   output logic [31:0] rsp_data_o,
   output logic        err_o,
   output logic [31:0] err_addr_o,
   output logic        mem_sel_o,
   output logic        mem_wen_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_wmask_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);

   localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [31:0]        addr_q, addr_d;
   logic [4:0]         rd_q, rd_d;
   logic               done_q, done_d, err_q, err_d, rsp_wen_q, rsp_wen_d;
   logic [4:0]         rsp_rd_q, rsp_rd_d;
   logic [31:0]        rsp_data_q, rsp_data_d, err_addr_q, err_addr_d;
   logic               mem_sel_q, mem_sel_d, mem_wen_q, mem_wen_d;
   logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]         mem_wmask_q, mem_wmask_d;

   logic               legal;
   logic [31:0]        byte_sh;
   logic [15:0]        half_sel;
   logic [31:0]        load_val;

   // Request legality: alignment, defined funct3, no unsigned stores
   always_comb begin
      legal = 1'b0;
      case (req_funct3_i)
         3'b000, 3'b100: legal = 1'b1;
         3'b001, 3'b101: legal = ~req_addr_i[0];
         3'b010:         legal = (req_addr_i[1:0] == 2'b00);
         default:        legal = 1'b0;
      endcase
      if (req_we_i && req_funct3_i[2]) legal = 1'b0;
   end

   // Extract and extend the addressed lane of the returned word
   always_comb begin
      byte_sh  = mem_rdata_i >> {addr_q[1:0], 3'b000};
      half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (funct3_q)
         3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
         3'b100:  load_val = {24'h000000, byte_sh[7:0]};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_val = {16'h0000, half_sel};
         default: load_val = mem_rdata_i;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      rd_d        = rd_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rsp_wen_d   = 1'b0;
      rsp_rd_d    = rsp_rd_q;
      rsp_data_d  = rsp_data_q;
      err_addr_d  = err_addr_q;
      mem_sel_d   = mem_sel_q;
      mem_wen_d   = mem_wen_q;
      mem_addr_d  = mem_addr_q;
      mem_wmask_d = mem_wmask_q;
      mem_wdata_d = mem_wdata_q;
      hold_o      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               if (!legal) begin
                  err_d      = 1'b1;
                  err_addr_d = req_addr_i;
               end else begin
                  hold_o      = 1'b1;
                  state_d     = ACCESS;
                  cnt_d       = '0;
                  funct3_d    = req_funct3_i;
                  addr_d      = req_addr_i;
                  rd_d        = req_rd_i;
                  mem_sel_d   = 1'b1;
                  mem_wen_d   = req_we_i;
                  mem_addr_d  = {req_addr_i[31:2], 2'b00};
                  mem_wmask_d = 4'b0000;
                  mem_wdata_d = req_wdata_i;
                  if (req_we_i) begin
                     case (req_funct3_i[1:0])
                        2'b00: begin
                           mem_wdata_d = {4{req_wdata_i[7:0]}};
                           mem_wmask_d = 4'b0001 << req_addr_i[1:0];
                        end
                        2'b01: begin
                           mem_wdata_d = {2{req_wdata_i[15:0]}};
                           mem_wmask_d = req_addr_i[1] ? 4'b1100 : 4'b0011;
                        end
                        default: mem_wmask_d = 4'b1111;
                     endcase
                  end
               end
            end
         end
         ACCESS: begin
            hold_o = 1'b1;
            if (mem_ack_i) begin
               state_d   = IDLE;
               mem_sel_d = 1'b0;
               mem_wen_d = 1'b0;
               done_d    = 1'b1;
               if (!mem_wen_q) begin
                  rsp_data_d = load_val;
                  rsp_rd_d   = rd_q;
                  rsp_wen_d  = (rd_q != 5'd0);
               end
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               state_d    = IDLE;
               mem_sel_d  = 1'b0;
               mem_wen_d  = 1'b0;
               err_d      = 1'b1;
               err_addr_d = addr_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         funct3_q    <= '0;
         addr_q      <= '0;
         rd_q        <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rsp_wen_q   <= 1'b0;
         rsp_rd_q    <= '0;
         rsp_data_q  <= '0;
         err_addr_q  <= '0;
         mem_sel_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wmask_q <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         rd_q        <= rd_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rsp_wen_q   <= rsp_wen_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_data_q  <= rsp_data_d;
         err_addr_q  <= err_addr_d;
         mem_sel_q   <= mem_sel_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wmask_q <= mem_wmask_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign done_o      = done_q;
   assign err_o       = err_q;
   assign rsp_wen_o   = rsp_wen_q;
   assign rsp_rd_o    = rsp_rd_q;
   assign rsp_data_o  = rsp_data_q;
   assign err_addr_o  = err_addr_q;
   assign mem_sel_o   = mem_sel_q;
   assign mem_wen_o   = mem_wen_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wmask_o = mem_wmask_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases followed by random ops against
// an arithmetic reference model of the load/store rules.
module tb_lsu;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i, req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [4:0]  req_rd_i;
   logic        hold_o, done_o, rsp_wen_o, err_o, mem_sel_o, mem_wen_o;
   logic [4:0]  rsp_rd_o;
   logic [31:0] rsp_data_o, err_addr_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_wmask_o;
   logic        mem_ack_i;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_rsp_data;
   logic [4:0]  m_rsp_rd;

   always #5 clk = ~clk;

   lsu #(.ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
      .hold_o(hold_o), .done_o(done_o), .rsp_wen_o(rsp_wen_o), .rsp_rd_o(rsp_rd_o),
      .rsp_data_o(rsp_data_o), .err_o(err_o), .err_addr_o(err_addr_o),
      .mem_sel_o(mem_sel_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
      .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_legal(input bit we, input int f3, input int unsigned a);
      if (we && f3 >= 4) return 0;
      if (f3 == 0 || f3 == 4) return 1;
      if (f3 == 1 || f3 == 5) return (a % 2) == 0;
      if (f3 == 2) return (a % 4) == 0;
      return 0;
   endfunction

   function automatic logic [3:0] m_mask(input int f3, input int unsigned a);
      if (f3 == 0) return 4'(1 << (a % 4));
      if (f3 == 1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
      if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
      if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input int f3, input int unsigned a, input logic [31:0] r);
      int unsigned v;
      int unsigned off = a % 4;
      if (f3 == 0 || f3 == 4) begin
         v = (r >> (8 * off)) & 32'hFF;
         if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
         return v;
      end
      if (f3 == 1 || f3 == 5) begin
         v = (r >> (16 * (off / 2))) & 32'hFFFF;
         if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
         return v;
      end
      return r;
   endfunction

   // One op: request at the current negedge, ack in ACCESS cycle ack_at (>TMO = never)
   task automatic do_op(input bit we, input int f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd,
                        input logic [31:0] rdata, input int ack_at, input string tag);
      bit lg = m_legal(we, f3, a);
      bit acked = 0;
      req_valid_i = 1; req_we_i = we; req_funct3_i = 3'(f3);
      req_addr_i = a; req_wdata_i = d; req_rd_i = rd;
      #1 chk({tag, " hold_req"}, 32'(hold_o), 32'(lg));
      @(posedge clk); @(negedge clk);
      req_valid_i = 0;
      if (!lg) begin
         chk({tag, " err"}, 32'(err_o), 1);
         chk({tag, " err_addr"}, err_addr_o, a);
         chk({tag, " sel_ill"}, 32'(mem_sel_o), 0);
         chk({tag, " hold_ill"}, 32'(hold_o), 0);
         return;
      end
      chk({tag, " sel"}, 32'(mem_sel_o), 1);
      chk({tag, " wen"}, 32'(mem_wen_o), 32'(we));
      chk({tag, " maddr"}, mem_addr_o, a & 32'hFFFFFFFC);
      chk({tag, " mask"}, 32'(mem_wmask_o), we ? 32'(m_mask(f3, a)) : 0);
      if (we) chk({tag, " wdata"}, mem_wdata_o, m_wdata(f3, d));
      for (int k = 1; k <= int'(TMO); k++) begin
         chk({tag, " sel_acc"}, 32'(mem_sel_o), 1);
         chk({tag, " hold_acc"}, 32'(hold_o), 1);
         mem_ack_i = (k == ack_at);
         mem_rdata_i = (k == ack_at) ? rdata : $urandom;
         @(posedge clk); @(negedge clk);
         mem_ack_i = 0;
         if (k == ack_at) begin acked = 1; break; end
         chk({tag, " done_early"}, 32'(done_o), 0);
      end
      chk({tag, " sel_end"}, 32'(mem_sel_o), 0);
      chk({tag, " hold_end"}, 32'(hold_o), 0);
      chk({tag, " done"}, 32'(done_o), 32'(acked));
      chk({tag, " err_end"}, 32'(err_o), 32'(!acked));
      if (!acked) chk({tag, " tmo_addr"}, err_addr_o, a);
      if (acked && !we) begin
         m_rsp_data = m_load(f3, a, rdata);
         m_rsp_rd = rd;
      end
      chk({tag, " rsp_wen"}, 32'(rsp_wen_o), 32'(acked && !we && rd != 0));
      chk({tag, " rsp_data"}, rsp_data_o, m_rsp_data);
      chk({tag, " rsp_rd"}, 32'(rsp_rd_o), 32'(m_rsp_rd));
   endtask

   initial begin
      int f3s [8] = '{0, 1, 2, 4, 5, 3, 6, 7};
      rst_n = 0; req_valid_i = 0; req_we_i = 0; req_funct3_i = 0;
      req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
      m_rsp_data = 0; m_rsp_rd = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      chk("rst sel", 32'(mem_sel_o), 0);
      chk("rst done", 32'(done_o), 0);
      chk("rst err", 32'(err_o), 0);
      chk("rst rsp_data", rsp_data_o, 0);
      chk("rst hold", 32'(hold_o), 0);

      // ack while idle is ignored
      mem_ack_i = 1; @(posedge clk); @(negedge clk); mem_ack_i = 0;
      chk("idle_ack done", 32'(done_o), 0);

      do_op(0, 2, 32'h100, 0, 5, 32'hDEADBEEF, 3, "lw");
      do_op(0, 0, 32'h103, 0, 7, 32'h80123456, 1, "lb");
      do_op(0, 4, 32'h103, 0, 7, 32'h80123456, 1, "lbu");
      do_op(0, 1, 32'h102, 0, 9, 32'h80011234, 2, "lh");
      do_op(1, 0, 32'h201, 32'h000000AB, 0, 0, 1, "sb");
      do_op(0, 2, 32'h102, 0, 3, 0, 1, "lw_mis");
      do_op(1, 4, 32'h200, 0, 3, 0, 1, "s_f3_100");
      do_op(0, 2, 32'h300, 0, 4, 32'h11, TMO + 1, "tmo");
      do_op(0, 2, 32'h304, 0, 4, 32'h22, TMO, "ack_last");

      // reset during the 3rd ACCESS cycle aborts the access
      req_valid_i = 1; req_we_i = 0; req_funct3_i = 3'b010; req_addr_i = 32'h400; req_rd_i = 6;
      @(posedge clk); @(negedge clk); req_valid_i = 0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("rstacc sel_before", 32'(mem_sel_o), 1);
      rst_n = 0;
      @(posedge clk); @(negedge clk);
      chk("rstacc sel", 32'(mem_sel_o), 0);
      chk("rstacc hold", 32'(hold_o), 0);
      chk("rstacc done", 32'(done_o), 0);
      chk("rstacc err", 32'(err_o), 0);
      rst_n = 1;
      m_rsp_data = 0; m_rsp_rd = 0;
      do_op(0, 2, 32'h404, 0, 8, 32'hCAFEF00D, 1, "lw_after_rst");

      for (int i = 0; i < 40; i++) begin
         bit we = 1'($urandom);
         int f3 = f3s[($urandom % 10 < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)];
         int ack = ($urandom % 8 == 0) ? int'(TMO) + 1 : $urandom_range(1, 4);
         do_op(we, f3, $urandom, $urandom, 5'($urandom), $urandom, ack, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
